goa_pin_master: RTL

GOA_PIN_MASTER -- requirements
Module: goa_pin_master

---
 rtl/goa_pin_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/goa_pin_master.sv
// Byte-serial pin master: pushes a header plus two data/read slots to the device
// over a four-phase HSTB/DACK handshake, with synchronised device inputs.
module goa_pin_master #(
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  pin_ui,
  output logic [7:0]  pin_uio_in,
  input  logic [7:0]  pin_uo,
  input  logic [7:0]  pin_uio_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACK_HI, ACK_LO, DONE} state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic                        we_q, we_d;
  logic [6:0]                  addr_q, addr_d;
  logic [15:0]                 wdata_q, wdata_d;
  logic [15:0]                 rdata_q, rdata_d;
  logic [SYNC_STAGES-1:0]      dack_sync_q, dack_sync_d;
  logic [SYNC_STAGES-1:0][7:0] uo_sync_q, uo_sync_d;

  logic       dack_s;
  logic [7:0] uo_s;
  logic [7:0] tx_byte;
  logic       tmo_hit;
  logic       hstb;
  logic       unused_uio;

  assign unused_uio = ^{pin_uio_out[7:2], pin_uio_out[0]};
  assign dack_s     = dack_sync_q[SYNC_STAGES-1];
  assign uo_s       = uo_sync_q[SYNC_STAGES-1];
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT));
  assign pin_uio_in = {7'b0, hstb};

  always_comb begin
    dack_sync_d = {dack_sync_q[SYNC_STAGES-2:0], pin_uio_out[1]};
    uo_sync_d   = {uo_sync_q[SYNC_STAGES-2:0], pin_uo};
  end

  // Read slots drive zero; the device answers on pin_uo instead.
  always_comb begin
    case (cnt_q)
      2'd0:    tx_byte = {we_q, addr_q};
      2'd1:    tx_byte = we_q ? wdata_q[15:8] : 8'h00;
      default: tx_byte = we_q ? wdata_q[7:0]  : 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 16'h0000;
    pin_ui    = 8'h00;
    hstb      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          rdata_d = 16'h0000;
          cnt_d   = 2'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        pin_ui  = tx_byte;
        tmo_d   = '0;
        state_d = ACK_HI;
      end
      ACK_HI: begin
        pin_ui = tx_byte;
        hstb   = 1'b1;
        if (dack_s) begin
          // uo travels through the same sync depth as DACK, so it is aligned here.
          if (!we_q && cnt_q == 2'd1) rdata_d[15:8] = uo_s;
          if (!we_q && cnt_q == 2'd2) rdata_d[7:0]  = uo_s;
          tmo_d   = '0;
          state_d = ACK_LO;
        end else if (tmo_hit) begin
          pin_ui    = 8'h00;
          hstb      = 1'b0;
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ACK_LO: begin
        pin_ui = tx_byte;
        if (!dack_s) begin
          if (cnt_q == 2'd2) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = SETUP;
          end
        end else if (tmo_hit) begin
          pin_ui    = 8'h00;
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? 16'h0000 : rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      dack_sync_q <= '0;
      uo_sync_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      dack_sync_q <= dack_sync_d;
      uo_sync_q   <= uo_sync_d;
    end
  end

endmodule
